// File: rtl/fifo_stream_reader.sv
// FIFO read-side drain engine: issues reads, absorbs the 1-cycle read latency
// and re-presents words on a valid/ready stream. Define FIFO_RD_LAST_EN for o_last.
module fifo_stream_reader #(
  parameter int SIZE_DATA = 8,
  parameter int PKT_LEN   = 4
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_flush,
  output logic                 o_fifo_rd_en,
  input  logic                 i_fifo_empty,
  input  logic [SIZE_DATA-1:0] i_fifo_data,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic [SIZE_DATA-1:0] o_data,
`ifdef FIFO_RD_LAST_EN
  output logic [1:0]           o_count,
  output logic                 o_last
`else
  output logic [1:0]           o_count
`endif
);

  logic [SIZE_DATA-1:0] r_head;
  logic [SIZE_DATA-1:0] r_tail;
  logic [1:0]           r_count;
  logic                 r_inflight;
  logic                 w_pop;
  logic                 w_cap;
  logic [2:0]           w_sum;

  assign w_pop = o_valid & i_ready;
  assign w_cap = r_inflight & ~i_flush;

  // Occupancy after this edge if a read returns next cycle; never underflows
  // because a pop implies r_count >= 1.
  assign w_sum = {1'b0, r_count} + {2'b00, r_inflight} - {2'b00, w_pop};

  assign o_fifo_rd_en = ~i_rst & ~i_flush & ~i_fifo_empty & (w_sum <= 3'd1);

  assign o_valid = (r_count != 2'd0);
  assign o_data  = r_head;
  assign o_count = r_count;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= 2'd0;
      r_inflight <= 1'b0;
    end else if (i_flush) begin
      r_count    <= 2'd0;
      r_inflight <= 1'b0;
    end else begin
      r_inflight <= o_fifo_rd_en;
      unique case ({w_cap, w_pop})
        2'b10: begin
          if (r_count == 2'd0) r_head <= i_fifo_data;
          else                 r_tail <= i_fifo_data;
          r_count <= r_count + 2'd1;
        end
        2'b01: begin
          r_head  <= r_tail;
          r_count <= r_count - 2'd1;
        end
        2'b11: begin
          if (r_count == 2'd1) begin
            r_head <= i_fifo_data;
          end else begin
            r_head <= r_tail;
            r_tail <= i_fifo_data;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef FIFO_RD_LAST_EN
  localparam int PW = $clog2(PKT_LEN) + 1;
  localparam logic [PW-1:0] LAST_IDX = PW'(PKT_LEN - 1);

  logic [PW-1:0] r_pkt;

  assign o_last = o_valid & (r_pkt == LAST_IDX);

  always_ff @(posedge i_clk) begin
    if (i_rst | i_flush) begin
      r_pkt <= '0;
    end else if (w_pop) begin
      r_pkt <= o_last ? '0 : r_pkt + PW'(1);
    end
  end
`endif

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Directed bench for fifo_stream_reader with a behavioural FIFO model
// and a per-cycle monitor of occupancy, empty-edge and stall stability.
module tb_fifo_stream_reader;

  localparam int PKT = 4;

  logic       i_clk = 1'b0;
  logic       i_rst;
  logic       i_flush;
  logic       o_fifo_rd_en;
  logic       fifo_empty;
  logic [7:0] fifo_data;
  logic       o_valid;
  logic       i_ready;
  logic [7:0] o_data;
  logic [1:0] o_count;
`ifdef FIFO_RD_LAST_EN
  logic       o_last;
`endif

  fifo_stream_reader #(.SIZE_DATA(8), .PKT_LEN(PKT)) dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_flush     (i_flush),
    .o_fifo_rd_en(o_fifo_rd_en),
    .i_fifo_empty(fifo_empty),
    .i_fifo_data (fifo_data),
    .o_valid     (o_valid),
    .i_ready     (i_ready),
    .o_data      (o_data),
`ifdef FIFO_RD_LAST_EN
    .o_count     (o_count),
    .o_last      (o_last)
`else
    .o_count     (o_count)
`endif
  );

  always #5 i_clk = ~i_clk;

  logic [7:0] mem [0:63];
  int         wr_ptr = 0;
  int         rd_ptr = 0;
  logic       fifo_clr;

  assign fifo_empty = (wr_ptr == rd_ptr);

  always @(posedge i_clk) begin
    if (fifo_clr) begin
      rd_ptr <= wr_ptr;
    end else if (o_fifo_rd_en) begin
      fifo_data <= mem[rd_ptr[5:0]];
      rd_ptr    <= rd_ptr + 1;
    end
  end

  task automatic push(input logic [7:0] v);
    mem[wr_ptr[5:0]] = v;
    wr_ptr = wr_ptr + 1;
  endtask

  int n_pass  = 0;
  int n_total = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  int         viol   = 0;
  logic       p_hold = 1'b0;
  logic       p_rd   = 1'b0;
  logic [7:0] p_data = 8'h00;

  always begin
    @(negedge i_clk);
    #2;
    if (!i_rst) begin
      if (int'(o_count) + int'(p_rd) > 2) viol++;
      if (o_fifo_rd_en && fifo_empty) viol++;
      if (o_valid !== (o_count != 2'd0)) viol++;
      if (p_hold && (!o_valid || o_data !== p_data)) viol++;
    end
    p_hold = o_valid & ~i_ready & ~i_flush & ~i_rst;
    p_data = o_data;
    p_rd   = o_fifo_rd_en;
  end

  int t2_rd [9]  = '{1, 1, 0, 0, 0, 1, 0, 0, 0};
  int t2_v  [9]  = '{0, 0, 1, 1, 1, 1, 1, 1, 0};
  int t2_c  [9]  = '{0, 0, 1, 2, 2, 2, 1, 1, 0};
  int t2_d  [9]  = '{0, 0, 'h11, 'h11, 'h11, 'h11, 'h22, 'h33, 0};
  int t4_rd [10] = '{1, 1, 0, 0, 1, 0, 1, 0, 0, 0};
  int t4_v  [10] = '{0, 0, 1, 1, 1, 1, 0, 0, 1, 0};
  int t4_c  [10] = '{0, 0, 1, 2, 2, 1, 0, 0, 1, 0};
  int t4_d  [10] = '{0, 0, 'hA0, 'hA0, 'hA0, 'hA1, 0, 0, 'hA3, 0};

  logic [15:0] pat = 16'b1011_0010_1101_1001;

  // Push three words after reset and expect back-to-back delivery from cycle 2.
  task automatic run3(input logic [7:0] a, input logic [7:0] b,
                      input logic [7:0] c);
    logic [7:0] w [3];
    w[0] = a; w[1] = b; w[2] = c;
    for (int k = 0; k < 6; k++) begin
      @(negedge i_clk);
      if (k == 0) begin
        i_rst = 1'b0; fifo_clr = 1'b0; i_flush = 1'b0; i_ready = 1'b1;
        push(a); push(b); push(c);
      end
      #1;
      chk("run3_rd", 32'(o_fifo_rd_en), 32'(k < 3));
      chk("run3_valid", 32'(o_valid), 32'(k >= 2 && k <= 4));
      chk("run3_count", 32'(o_count), 32'(k >= 2 && k <= 4));
      if (k == 0) chk("run3_data0", 32'(o_data), 32'h0);
      if (k >= 2 && k <= 4) chk("run3_data", 32'(o_data), 32'(w[k-2]));
    end
  endtask

  task automatic drain(input logic [7:0] base, input int n);
    int k;
    k = 0;
    for (int cy = 0; cy < 200 && k < n; cy++) begin
      @(negedge i_clk);
      if (cy == 0) for (int j = 0; j < n; j++) push(base + 8'(j));
      i_ready = pat[cy % 16];
      #1;
      if (o_valid) begin
        chk("drain_data", 32'(o_data), 32'(base + 8'(k)));
`ifdef FIFO_RD_LAST_EN
        chk("drain_last", 32'(o_last), 32'((k % PKT) == PKT - 1));
`endif
        if (i_ready) k++;
      end
    end
    chk("drain_done", 32'(k), 32'(n));
  endtask

  initial begin
    i_rst = 1'b1; i_flush = 1'b0; i_ready = 1'b0; fifo_clr = 1'b1;

    for (int k = 0; k < 2; k++) begin
      @(negedge i_clk);
      #1;
      chk("rst_rd", 32'(o_fifo_rd_en), 32'h0);
      chk("rst_valid", 32'(o_valid), 32'h0);
      chk("rst_count", 32'(o_count), 32'h0);
      chk("rst_data", 32'(o_data), 32'h0);
    end

    run3(8'h11, 8'h22, 8'h33);

    for (int k = 0; k < 9; k++) begin
      @(negedge i_clk);
      if (k == 0) begin
        i_ready = 1'b0;
        push(8'h11); push(8'h22); push(8'h33);
      end
      if (k == 5) i_ready = 1'b1;
      #1;
      chk("stall_rd", 32'(o_fifo_rd_en), 32'(t2_rd[k]));
      chk("stall_valid", 32'(o_valid), 32'(t2_v[k]));
      chk("stall_count", 32'(o_count), 32'(t2_c[k]));
      if (t2_v[k] != 0) chk("stall_data", 32'(o_data), 32'(t2_d[k]));
    end

    for (int k = 0; k < 6; k++) begin
      @(negedge i_clk);
      i_ready = k[0];
      #1;
      chk("empty_rd", 32'(o_fifo_rd_en), 32'h0);
      chk("empty_valid", 32'(o_valid), 32'h0);
    end

    for (int k = 0; k < 10; k++) begin
      @(negedge i_clk);
      case (k)
        0: begin i_ready = 1'b0; push(8'hA0); push(8'hA1); end
        3: push(8'hA2);
        4: i_ready = 1'b1;
        5: begin i_ready = 1'b0; i_flush = 1'b1; push(8'hA3); end
        6: begin i_ready = 1'b1; i_flush = 1'b0; end
        default: ;
      endcase
      #1;
      chk("flush_rd", 32'(o_fifo_rd_en), 32'(t4_rd[k]));
      chk("flush_valid", 32'(o_valid), 32'(t4_v[k]));
      chk("flush_count", 32'(o_count), 32'(t4_c[k]));
      if (t4_v[k] != 0) chk("flush_data", 32'(o_data), 32'(t4_d[k]));
    end

    for (int k = 0; k < 5; k++) begin
      @(negedge i_clk);
      case (k)
        0: begin
          i_ready = 1'b1;
          for (int j = 0; j < 6; j++) push(8'hB0 + 8'(j));
        end
        1: i_ready = 1'b0;
        2: i_ready = 1'b1;
        3: i_ready = 1'b0;
        default: begin i_rst = 1'b1; fifo_clr = 1'b1; i_ready = 1'b1; end
      endcase
      #1;
      if (k == 2) chk("mid_data0", 32'(o_data), 32'hB0);
      if (k == 3) chk("mid_data1", 32'(o_data), 32'hB1);
      if (k == 4) chk("mid_rst_rd", 32'(o_fifo_rd_en), 32'h0);
    end
    run3(8'hC0, 8'hC1, 8'hC2);

    @(negedge i_clk);
    i_flush = 1'b1; i_ready = 1'b0;
    @(negedge i_clk);
    i_flush = 1'b0;
    drain(8'h00, 8);
    drain(8'h20, 6);
    @(negedge i_clk);
    i_flush = 1'b1; i_ready = 1'b0;
    @(negedge i_clk);
    i_flush = 1'b0;
    drain(8'h30, 4);

    repeat (2) @(negedge i_clk);
    chk("invariant", 32'(viol), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
